magma_result_viewer: RTL and testbench

- Consumer end of the cipher core's 128-bit result interface; the counterpart of the nibble-entry data driver.
- Accepts one 128-bit result via valid/ready and holds it.
- User pages through it, 32 bits at a time, on the eight 7-segment digits (A_0..A_3, B_0..B_3) with board buttons.
- User releases it with an acknowledge button, which re-opens the interface.

---
 rtl/magma_result_viewer.sv | 117 +++++++++++
 tb/tb_magma_result_viewer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/magma_result_viewer.sv
// magma_result_viewer: holds one 128-bit cipher result and pages it 32 bits at a time onto eight 7-seg digits; MAGMA_VIEWER_AUTOSCROLL_EN adds timed paging
module magma_result_viewer #(
  parameter int unsigned SCROLL_DIV = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] res_data,
  input  logic         res_valid,
  output logic         res_ready,
  input  logic [2:0]   bat,
  output logic         s_led,
  output logic [3:0]   Gr_pos_led,
  output logic [6:0]   A_0seg7,
  output logic [6:0]   A_1seg7,
  output logic [6:0]   A_2seg7,
  output logic [6:0]   A_3seg7,
  output logic [6:0]   B_0seg7,
  output logic [6:0]   B_1seg7,
  output logic [6:0]   B_2seg7,
  output logic [6:0]   B_3seg7
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;
  localparam logic [6:0] DASH = 7'b0111111;
  logic [0:0]   state;
  logic [127:0] held;
  logic [1:0]   page;
  logic [2:0]   s1, s2, s3, push;
  logic [6:0]   seg [8];
  logic [31:0]  cur;
  logic         nxt, prv, ack, auto_adv;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction
  assign nxt = push == 3'b001;
  assign prv = push == 3'b010;
  assign ack = push == 3'b100;
  assign cur = held[{page, 5'b0} +: 32];
  // two-flop synchroniser, one more stage for edge history, registered falling-edge pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1   <= '1;
      s2   <= '1;
      s3   <= '1;
      push <= '0;
    end else begin
      s1   <= bat;
      s2   <= s1;
      s3   <= s2;
      push <= s3 & ~s2;
    end
`ifdef MAGMA_VIEWER_AUTOSCROLL_EN
  logic [31:0] cnt;
  assign auto_adv = state == SHOW && cnt == 32'(SCROLL_DIV - 1) && !nxt && !prv && !ack;
  // page timer: idles at zero outside SHOW and restarts on every manual page move
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (state != SHOW || nxt || prv || ack || cnt == 32'(SCROLL_DIV - 1)) ? '0 : cnt + 32'd1;
`else
  assign auto_adv = 1'b0;
`endif
  // handshake and paging: capture in IDLE, single-button pushes steer SHOW
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      held      <= '0;
      page      <= '0;
      res_ready <= 1'b0;
    end else if (state == IDLE) begin
      res_ready <= !(res_valid && res_ready);
      if (res_valid && res_ready) begin
        held  <= res_data;
        page  <= '0;
        state <= SHOW;
      end
    end else if (ack) begin
      state     <= IDLE;
      res_ready <= 1'b1;
    end else if (nxt || auto_adv) page <= page + 2'd1;
    else if (prv) page <= page - 2'd1;
  // registered display driven from the state and page of the previous edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s_led      <= 1'b0;
      Gr_pos_led <= '0;
      for (int i = 0; i < 8; i++) seg[i] <= DASH;
    end else begin
      s_led      <= state == SHOW;
      Gr_pos_led <= state == SHOW ? 4'b0001 << page : 4'b0000;
      for (int i = 0; i < 8; i++) seg[i] <= state == SHOW ? hex7(cur[4*i +: 4]) : DASH;
    end
  assign A_0seg7 = seg[0];
  assign A_1seg7 = seg[1];
  assign A_2seg7 = seg[2];
  assign A_3seg7 = seg[3];
  assign B_0seg7 = seg[4];
  assign B_1seg7 = seg[5];
  assign B_2seg7 = seg[6];
  assign B_3seg7 = seg[7];
endmodule

// File: tb/tb_magma_result_viewer.sv
// tb_magma_result_viewer: directed self-checking bench for magma_result_viewer
module tb_magma_result_viewer;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, SA = 7'b0001000, SF = 7'b0001110;
  localparam logic [127:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D2 = 128'hFFFFFFFF_00000000_11111111_000000A5;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [127:0] res_data = '0;
  logic res_valid = 1'b0;
  logic res_ready;
  logic [2:0] bat = 3'b111;
  logic s_led;
  logic [3:0] gr;
  logic [6:0] a0, a1, a2, a3, b0, b1, b2, b3;
  int tests = 0;
  int fails = 0;
  magma_result_viewer #(.SCROLL_DIV(4)) dut (
    .clk(clk), .reset(reset), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .bat(bat), .s_led(s_led), .Gr_pos_led(gr),
    .A_0seg7(a0), .A_1seg7(a1), .A_2seg7(a2), .A_3seg7(a3),
    .B_0seg7(b0), .B_1seg7(b1), .B_2seg7(b2), .B_3seg7(b3)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [2:0] m);
    bat = ~m;
    step(2);
    bat = 3'b111;
    step(6);
  endtask
  task automatic capture(input logic [127:0] d);
    res_data  = d;
    res_valid = 1'b1;
    step(1);
    res_valid = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    step(5);
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", res_ready); end
    tests++; if ({a0, a3, b0, b3} !== {4{DASH}}) begin fails++; $display("FAIL reset_dash got %h exp %h", {a0, a3, b0, b3}, {4{DASH}}); end
    tests++; if ({gr, s_led} !== 5'b0) begin fails++; $display("FAIL reset_leds got %b exp 00000", {gr, s_led}); end
    reset = 1'b1;
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL release_ready_pre got %b exp 0", res_ready); end
    step(1);
    tests++; if (res_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b exp 1", res_ready); end
  endtask
  task automatic test_capture;
    capture(D1);
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL capture_ready got %b exp 0", res_ready); end
    step(1);
    tests++; if ({a0, a1, b3} !== {S0, S1, S7}) begin fails++; $display("FAIL capture_digits got %h exp %h", {a0, a1, b3}, {S0, S1, S7}); end
    tests++; if ({gr, s_led} !== 5'b00011) begin fails++; $display("FAIL capture_leds got %b exp 00011", {gr, s_led}); end
  endtask
  task automatic test_paging;
    press(3'b010);
    tests++; if ({a0, b3, gr} !== {S7, S0, 4'b1000}) begin fails++; $display("FAIL prev_wrap got %h exp %h", {a0, b3, gr}, {S7, S0, 4'b1000}); end
    press(3'b001);
    tests++; if ({a0, gr} !== {S0, 4'b0001}) begin fails++; $display("FAIL next_wrap got %h exp %h", {a0, gr}, {S0, 4'b0001}); end
    press(3'b001);
    tests++; if ({a0, b3, gr} !== {S8, SF, 4'b0010}) begin fails++; $display("FAIL next_page1 got %h exp %h", {a0, b3, gr}, {S8, SF, 4'b0010}); end
    press(3'b001);
    tests++; if ({a0, b3, gr} !== {SF, S8, 4'b0100}) begin fails++; $display("FAIL next_page2 got %h exp %h", {a0, b3, gr}, {SF, S8, 4'b0100}); end
    press(3'b010);
    press(3'b010);
  endtask
  task automatic test_conflict;
    press(3'b011);
    tests++; if ({a0, gr} !== {S0, 4'b0001}) begin fails++; $display("FAIL dual_push got %h exp %h", {a0, gr}, {S0, 4'b0001}); end
    res_data  = D2;
    res_valid = 1'b1;
    step(3);
    tests++; if (res_ready !== 1'b0) begin fails++; $display("FAIL show_ready got %b exp 0", res_ready); end
    tests++; if ({a0, b3, gr} !== {S0, S7, 4'b0001}) begin fails++; $display("FAIL show_ignore_valid got %h exp %h", {a0, b3, gr}, {S0, S7, 4'b0001}); end
    res_valid = 1'b0;
  endtask
  task automatic test_ack;
    int n = 0;
    bat = 3'b011;
    step(2);
    bat = 3'b111;
    while (res_ready !== 1'b1 && n < 10) begin step(1); n++; end
    tests++; if (res_ready !== 1'b1) begin fails++; $display("FAIL ack_timeout got %b exp 1", res_ready); end
    tests++; if (s_led !== 1'b1) begin fails++; $display("FAIL ack_led_lag got %b exp 1", s_led); end
    capture(D2);
    tests++; if ({res_ready, a0, b3, gr, s_led} !== {1'b0, DASH, DASH, 5'b0}) begin fails++; $display("FAIL ack_idle_view got %h exp %h", {res_ready, a0, b3, gr, s_led}, {1'b0, DASH, DASH, 5'b0}); end
    step(1);
    tests++; if ({a0, a1, b3, gr} !== {S5, SA, S0, 4'b0001}) begin fails++; $display("FAIL recapture got %h exp %h", {a0, a1, b3, gr}, {S5, SA, S0, 4'b0001}); end
    press(3'b001);
    tests++; if ({a0, b3} !== {S1, S1}) begin fails++; $display("FAIL recapture_page1 got %h exp %h", {a0, b3}, {S1, S1}); end
  endtask
  task automatic test_mid_reset;
    #2 reset = 1'b0;
    #1;
    tests++; if ({res_ready, s_led, gr, a0, b3} !== {6'b0, DASH, DASH}) begin fails++; $display("FAIL mid_reset got %h exp %h", {res_ready, s_led, gr, a0, b3}, {6'b0, DASH, DASH}); end
    step(2);
    reset = 1'b1;
    step(1);
    tests++; if ({res_ready, s_led} !== 2'b10) begin fails++; $display("FAIL mid_reset_release got %b exp 10", {res_ready, s_led}); end
  endtask
`ifdef MAGMA_VIEWER_AUTOSCROLL_EN
  task automatic test_autoscroll;
    capture(D1);
    step(2);
    bat = 3'b110;
    step(2);
    bat = 3'b111;
    step(1);
    tests++; if (gr !== 4'b0010) begin fails++; $display("FAIL auto_first got %b exp 0010", gr); end
    step(2);
    tests++; if (gr !== 4'b0100) begin fails++; $display("FAIL auto_push got %b exp 0100", gr); end
    step(3);
    tests++; if (gr !== 4'b0100) begin fails++; $display("FAIL auto_restart got %b exp 0100", gr); end
    step(1);
    tests++; if (gr !== 4'b1000) begin fails++; $display("FAIL auto_after_push got %b exp 1000", gr); end
  endtask
`endif
  initial begin
    #1;
    test_reset;
    test_capture;
    test_paging;
    test_conflict;
    test_ack;
    test_mid_reset;
`ifdef MAGMA_VIEWER_AUTOSCROLL_EN
    test_autoscroll;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
